// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller and MEM/WB register for the
// five-stage pipeline. Issues loads/stores to a variable-latency memory with
// a req/done handshake and stalls upstream while an access is outstanding.
// Optional watchdog: define MEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles without mem_done.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] XOut_in,
  input  logic [15:0] read2Data_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        halt_in,
  input  logic        createdump_in,
  input  logic        link_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [15:0] PC_plus_two_in,
  input  logic [2:0]  Write_register_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_out,
  output logic        err_out,
  output logic [15:0] WB_data_out,
  output logic [2:0]  Write_register_out,
  output logic        RegWrite_out,
  output logic        halt_out,
  output logic        createdump_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr, r_wdata;
  logic        r_wr;
  logic        w_capture;
  logic        w_access;
  logic [15:0] w_sel_data;

  // next values for the MEM/WB register
  logic [15:0] w_wb_data;
  logic [2:0]  w_wreg;
  logic        w_rw, w_halt, w_dump;

  // MEM/WB stage register
  logic [15:0] r_wb_data;
  logic [2:0]  r_wreg;
  logic        r_rw, r_halt, r_dump;

  assign w_access = MemRead_in | MemWrite_in;
  // a store (including the illegal read+write combination) never writes back memory data
  assign w_sel_data = link_in ? PC_plus_two_in :
                      (MemtoReg_in & ~MemWrite_in) ? mem_rdata : XOut_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 7) ? $clog2(TIMEOUT_CYCLES + 1) : 7;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT_CYCLES)) && !mem_done;

  // r_cnt holds the 1-based index of the current WAIT cycle
  always_ff @(posedge clk) begin
    if (rst)             r_cnt <= '0;
    else if (w_capture)  r_cnt <= CW'(1);
    else if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES < 2);
`endif

  // next-state, handshake outputs and next MEM/WB contents
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0;
    mem_wdata   = 16'h0;
    stall_out   = 1'b0;
    err_out     = 1'b0;
    w_capture   = 1'b0;
    w_wb_data   = 16'h0;
    w_wreg      = 3'd0;
    w_rw        = 1'b0;
    w_halt      = 1'b0;
    w_dump      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_access) begin
          w_wb_data = w_sel_data;
          w_wreg    = Write_register_in;
          w_rw      = RegWrite_in;
          w_halt    = halt_in;
          w_dump    = createdump_in;
        end else if (XOut_in[0]) begin
          err_out = 1'b1;
          w_halt  = 1'b1;
        end else begin
          mem_req     = 1'b1;
          mem_wr      = MemWrite_in;
          mem_addr    = XOut_in;
          mem_wdata   = read2Data_in;
          stall_out   = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req   = 1'b1;
        mem_wr    = r_wr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        stall_out = !mem_done;
        if (mem_done) begin
          w_wb_data   = w_sel_data;
          w_wreg      = Write_register_in;
          w_rw        = RegWrite_in;
          w_halt      = halt_in;
          w_dump      = createdump_in;
          w_state_nxt = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_timeout) begin
          mem_req     = 1'b0;
          mem_wr      = 1'b0;
          mem_addr    = 16'h0;
          mem_wdata   = 16'h0;
          stall_out   = 1'b0;
          err_out     = 1'b1;
          w_halt      = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // all outputs read 0 while reset is held
    if (rst) begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0;
      mem_wdata = 16'h0;
      stall_out = 1'b0;
      err_out   = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // hold address/data stable for the whole access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 16'h0;
      r_wdata <= 16'h0;
      r_wr    <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= XOut_in;
      r_wdata <= read2Data_in;
      r_wr    <= MemWrite_in;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_data <= 16'h0;
      r_wreg    <= 3'd0;
      r_rw      <= 1'b0;
      r_halt    <= 1'b0;
      r_dump    <= 1'b0;
    end else begin
      r_wb_data <= w_wb_data;
      r_wreg    <= w_wreg;
      r_rw      <= w_rw;
      r_halt    <= w_halt;
      r_dump    <= w_dump;
    end
  end

  assign WB_data_out        = r_wb_data;
  assign Write_register_out = r_wreg;
  assign RegWrite_out       = r_rw;
  assign halt_out           = r_halt;
  assign createdump_out     = r_dump;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table vectors, hand sequences for
// multi-cycle cases, and randomized instructions against a transaction model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] XOut_in, read2Data_in, PC_plus_two_in, mem_rdata;
  logic        MemRead_in, MemWrite_in, halt_in, createdump_in, link_in;
  logic        MemtoReg_in, RegWrite_in, mem_done;
  logic [2:0]  Write_register_in;
  logic        mem_req, mem_wr, stall_out, err_out;
  logic [15:0] mem_addr, mem_wdata, WB_data_out;
  logic [2:0]  Write_register_out;
  logic        RegWrite_out, halt_out, createdump_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .XOut_in(XOut_in), .read2Data_in(read2Data_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .halt_in(halt_in),
    .createdump_in(createdump_in), .link_in(link_in), .MemtoReg_in(MemtoReg_in),
    .RegWrite_in(RegWrite_in), .PC_plus_two_in(PC_plus_two_in),
    .Write_register_in(Write_register_in), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .stall_out(stall_out), .err_out(err_out),
    .WB_data_out(WB_data_out), .Write_register_out(Write_register_out),
    .RegWrite_out(RegWrite_out), .halt_out(halt_out), .createdump_out(createdump_out)
  );

  typedef struct {
    logic [15:0] xout, r2, pc2;
    logic        mr, mw, halt, dump, link, m2r, rw;
    logic [2:0]  wreg;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        e_err;
    logic        e_full;   // compare data/register fields too
    logic [15:0] e_wb;
    logic [2:0]  e_wreg;
    logic        e_rw, e_halt, e_dump;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input instr_t in);
    XOut_in = in.xout; read2Data_in = in.r2; PC_plus_two_in = in.pc2;
    MemRead_in = in.mr; MemWrite_in = in.mw; halt_in = in.halt;
    createdump_in = in.dump; link_in = in.link; MemtoReg_in = in.m2r;
    RegWrite_in = in.rw; Write_register_in = in.wreg;
  endtask

  function automatic instr_t nop();
    instr_t n;
    n = '{xout: 16'h0, r2: 16'h0, pc2: 16'h0, mr: 1'b0, mw: 1'b0, halt: 1'b0,
          dump: 1'b0, link: 1'b0, m2r: 1'b0, rw: 1'b0, wreg: 3'd0};
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic [15:0] wb, input logic [2:0] wreg,
                        input logic rw, input logic hlt, input logic dmp);
    chk({tag, ".wb"},   WB_data_out, wb);
    chk({tag, ".wreg"}, {13'h0, Write_register_out}, {13'h0, wreg});
    chk({tag, ".rw"},   {15'h0, RegWrite_out}, {15'h0, rw});
    chk({tag, ".halt"}, {15'h0, halt_out}, {15'h0, hlt});
    chk({tag, ".dump"}, {15'h0, createdump_out}, {15'h0, dmp});
  endtask

  // Model: what a completed instruction writes back, using read data rd.
  function automatic logic [15:0] wb_value(input instr_t in, input logic [15:0] rd);
    if (in.link)              return in.pc2;
    else if (in.mw)           return in.xout;
    else if (in.m2r && in.mr) return rd;
    else                      return in.xout;
  endfunction

  // One instruction through the stage. lat = WAIT cycles until mem_done.
  task automatic run_instr(input string tag, input instr_t in, input int lat, input logic [15:0] rd);
    logic acc;
    acc = in.mr | in.mw;
    apply(in);
    mem_done = 1'b0;
    if (!acc || in.xout[0]) begin
      mem_rdata = 16'h0;
      #1;
      chk({tag, ".req"},   {15'h0, mem_req}, 16'h0);
      chk({tag, ".stall"}, {15'h0, stall_out}, 16'h0);
      chk({tag, ".err"},   {15'h0, err_out}, {15'h0, acc});
      tick();
      if (!acc) chk_wb(tag, wb_value(in, 16'h0), in.wreg, in.rw, in.halt, in.dump);
      else begin
        chk({tag, ".mis_halt"}, {15'h0, halt_out}, 16'h1);
        chk({tag, ".mis_rw"},   {15'h0, RegWrite_out}, 16'h0);
        chk({tag, ".mis_dump"}, {15'h0, createdump_out}, 16'h0);
      end
    end else begin
      for (int c = 0; c <= lat; c++) begin
        mem_done  = (c == lat && c != 0);
        mem_rdata = mem_done ? rd : 16'($urandom);
        #1;
        chk({tag, ".req"},   {15'h0, mem_req}, 16'h1);
        chk({tag, ".stall"}, {15'h0, stall_out}, {15'h0, (c != lat)});
        chk({tag, ".err"},   {15'h0, err_out}, 16'h0);
        chk({tag, ".wr"},    {15'h0, mem_wr}, {15'h0, in.mw});
        chk({tag, ".addr"},  mem_addr, in.xout);
        chk({tag, ".wdata"}, mem_wdata, in.r2);
        tick();
        if (c < lat) chk_wb({tag, ".bub"}, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        else         chk_wb(tag, wb_value(in, rd), in.wreg, in.rw, in.halt, in.dump);
      end
      mem_done = 1'b0;
    end
  endtask

  vec_t vecs[7];
  instr_t ri;

  initial begin
    rst = 1'b1; mem_done = 1'b0; mem_rdata = 16'h0;
    apply(nop());
    tick();
    chk("rst.req", {15'h0, mem_req}, 16'h0);
    chk("rst.stall", {15'h0, stall_out}, 16'h0);
    chk("rst.err", {15'h0, err_out}, 16'h0);
    chk_wb("rst", 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // single-cycle IDLE cases: non-memory and misaligned accesses
    for (int i = 0; i < 7; i++) begin
      vecs[i].in = nop(); vecs[i].e_err = 1'b0; vecs[i].e_full = 1'b1;
      vecs[i].e_wb = 16'h0; vecs[i].e_wreg = 3'd0;
      vecs[i].e_rw = 1'b0; vecs[i].e_halt = 1'b0; vecs[i].e_dump = 1'b0;
    end
    vecs[0].in.xout = 16'h1234; vecs[0].in.rw = 1'b1; vecs[0].in.wreg = 3'd3;
    vecs[0].e_wb = 16'h1234; vecs[0].e_wreg = 3'd3; vecs[0].e_rw = 1'b1;
    vecs[1].in.xout = 16'h5555; vecs[1].in.link = 1'b1; vecs[1].in.pc2 = 16'h0102;
    vecs[1].in.rw = 1'b1; vecs[1].in.wreg = 3'd7;
    vecs[1].e_wb = 16'h0102; vecs[1].e_wreg = 3'd7; vecs[1].e_rw = 1'b1;
    vecs[2].in.halt = 1'b1; vecs[2].e_halt = 1'b1;
    vecs[3].in.dump = 1'b1; vecs[3].in.xout = 16'h00FF; vecs[3].e_dump = 1'b1;
    vecs[3].e_wb = 16'h00FF;
    vecs[4].in.xout = 16'h0041; vecs[4].in.mr = 1'b1; vecs[4].in.m2r = 1'b1;
    vecs[4].in.rw = 1'b1; vecs[4].e_err = 1'b1; vecs[4].e_halt = 1'b1; vecs[4].e_full = 1'b0;
    vecs[5].in.xout = 16'h0013; vecs[5].in.mw = 1'b1; vecs[5].in.dump = 1'b1;
    vecs[5].e_err = 1'b1; vecs[5].e_halt = 1'b1; vecs[5].e_full = 1'b0;
    // vecs[6] is a nop: halt_out must drop after its single cycle

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].in);
      #1;
      chk($sformatf("vec%0d.req", i), {15'h0, mem_req}, 16'h0);
      chk($sformatf("vec%0d.stall", i), {15'h0, stall_out}, 16'h0);
      chk($sformatf("vec%0d.err", i), {15'h0, err_out}, {15'h0, vecs[i].e_err});
      tick();
      chk($sformatf("vec%0d.halt", i), {15'h0, halt_out}, {15'h0, vecs[i].e_halt});
      chk($sformatf("vec%0d.rw", i), {15'h0, RegWrite_out}, {15'h0, vecs[i].e_rw});
      chk($sformatf("vec%0d.dump", i), {15'h0, createdump_out}, {15'h0, vecs[i].e_dump});
      if (vecs[i].e_full) begin
        chk($sformatf("vec%0d.wb", i), WB_data_out, vecs[i].e_wb);
        chk($sformatf("vec%0d.wreg", i), {13'h0, Write_register_out}, {13'h0, vecs[i].e_wreg});
      end
    end

    // load, done on the 3rd WAIT cycle, then a nop to see WB data last one cycle
    ri = nop(); ri.xout = 16'h0040; ri.mr = 1'b1; ri.m2r = 1'b1; ri.rw = 1'b1; ri.wreg = 3'd5;
    run_instr("load3", ri, 3, 16'hBEEF);
    run_instr("after_load", nop(), 0, 16'h0);

    // store: address/data held, RegWrite passes through (0)
    ri = nop(); ri.xout = 16'h0010; ri.r2 = 16'h00AA; ri.mw = 1'b1;
    run_instr("store", ri, 2, 16'h7777);

    // reset asserted on the 2nd WAIT cycle
    ri = nop(); ri.xout = 16'h0080; ri.mr = 1'b1; ri.m2r = 1'b1; ri.rw = 1'b1; ri.wreg = 3'd2;
    apply(ri);
    tick();            // issue
    tick();            // WAIT 1
    rst = 1'b1;        // WAIT 2
    apply(nop());
    tick();
    rst = 1'b0;
    #1;
    chk("rstw.req", {15'h0, mem_req}, 16'h0);
    chk("rstw.stall", {15'h0, stall_out}, 16'h0);
    chk_wb("rstw", 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("rstw.late_req", {15'h0, mem_req}, 16'h0);
    chk("rstw.late_stall", {15'h0, stall_out}, 16'h0);
    tick();
    mem_done = 1'b0;
    chk_wb("rstw.late", 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);

    // randomized instruction stream, back-to-back accesses included
    for (int n = 0; n < 300; n++) begin
      int kind;
      ri.xout = 16'($urandom); ri.r2 = 16'($urandom); ri.pc2 = 16'($urandom);
      ri.wreg = 3'($urandom); ri.rw = 1'($urandom); ri.link = ($urandom_range(0, 5) == 0);
      ri.halt = ($urandom_range(0, 15) == 0); ri.dump = ($urandom_range(0, 15) == 0);
      ri.mr = 1'b0; ri.mw = 1'b0; ri.m2r = 1'b0;
      kind = $urandom_range(0, 7);
      if (kind <= 2) begin
        ri.mr = 1'b1; ri.m2r = 1'($urandom);
      end else if (kind <= 4) begin
        ri.mw = 1'b1; ri.mr = ($urandom_range(0, 7) == 0);
      end
      if ((ri.mr | ri.mw) && kind != 5) ri.xout[0] = 1'b0;
      if (kind == 5) begin ri.mr = 1'b1; ri.xout[0] = 1'b1; end
      run_instr($sformatf("rnd%0d", n), ri, $urandom_range(1, 4), 16'($urandom));
    end

`ifdef MEM_TIMEOUT_EN
    // watchdog fires on the 4th WAIT cycle with no mem_done
    ri = nop(); ri.xout = 16'h0200; ri.mr = 1'b1; ri.m2r = 1'b1; ri.rw = 1'b1; ri.wreg = 3'd1;
    apply(ri);
    mem_done = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      #1;
      chk("to.req", {15'h0, mem_req}, {15'h0, (c < 4)});
      chk("to.stall", {15'h0, stall_out}, {15'h0, (c < 4)});
      chk("to.err", {15'h0, err_out}, {15'h0, (c == 4)});
      tick();
      if (c < 4) chk_wb("to.bub", 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      else begin
        chk("to.halt", {15'h0, halt_out}, 16'h1);
        chk("to.rw", {15'h0, RegWrite_out}, 16'h0);
      end
    end
    apply(nop());
    #1;
    chk("to.idle_req", {15'h0, mem_req}, 16'h0);
    tick();
    // mem_done in the timeout cycle wins
    run_instr("to_done", ri, 4, 16'h4321);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
